// File: rtl/stepper_phase_monitor.sv
// Watches an asynchronous 4-phase stepper drive, debounces the coil pattern and
// tracks a saturating signed step position with soft-limit flags and fault detection.
module stepper_phase_monitor #(
  parameter int STABLE_CYCLES = 16,
  parameter int POS_WIDTH     = 16,
  parameter int LIMIT_FWD     = 400,
  parameter int LIMIT_BWD     = -400
) (
  input  logic                        CLK100MHZ,
  input  logic                        CPU_RESETN,
  input  logic [3:0]                  coil,
  input  logic                        zero_pos,
  input  logic                        clear_fault,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        step_pulse,
  output logic                        step_dir,
  output logic                        energized,
  output logic                        fault,
  output logic [1:0]                  fault_code,
  output logic                        at_fwd_limit,
  output logic                        at_bwd_limit
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

  typedef enum logic [1:0] {NOREF, TRACK, FAULT} state_t;

  function automatic logic signed [POS_WIDTH-1:0] sat_inc(input logic signed [POS_WIDTH-1:0] v);
    return (v == POS_MAX) ? v : v + POS_ONE;
  endfunction

  function automatic logic signed [POS_WIDTH-1:0] sat_dec(input logic signed [POS_WIDTH-1:0] v);
    return (v == POS_MIN) ? v : v - POS_ONE;
  endfunction

  // {is_phase, phase}
  function automatic logic [2:0] decode(input logic [3:0] c);
    case (c)
      4'b1001: return 3'b100;
      4'b1010: return 3'b101;
      4'b0110: return 3'b110;
      4'b0101: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  logic [3:0]    coil_p0, coil_p1, cand;
  logic [CW-1:0] stab_cnt;
  logic [3:0]    pat_p2;
  logic          vld_p2;

  // Stage 0/1: two-flop synchronizer; stage 2: stability filter and accepted pattern
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      coil_p0  <= '0;
      coil_p1  <= '0;
      cand     <= '0;
      stab_cnt <= '0;
      pat_p2   <= '0;
      vld_p2   <= 1'b0;
    end else begin
      coil_p0 <= coil;
      coil_p1 <= coil_p0;
      vld_p2  <= 1'b0;
      if (coil_p1 != cand) begin
        cand     <= coil_p1;
        stab_cnt <= CW'(1);
      end else if (stab_cnt != CW'(STABLE_CYCLES)) begin
        stab_cnt <= stab_cnt + CW'(1);
      end
      if (coil_p1 == cand && stab_cnt == CW'(STABLE_CYCLES - 1) && cand != pat_p2) begin
        pat_p2 <= cand;
        vld_p2 <= 1'b1;
      end
    end
  end

  state_t                      state;
  logic [1:0]                  q;
  logic [2:0]                  dec;
  logic                        is_ph, is_ill, new_pat;
  logic                        step_fwd, step_bwd, step_opp;
  logic signed [POS_WIDTH-1:0] pos_nxt;
  logic signed [31:0]          pos_ext;

  assign dec      = decode(pat_p2);
  assign is_ph    = dec[2];
  assign is_ill   = !is_ph && (pat_p2 != 4'b0000);
  assign new_pat  = vld_p2 && (state == TRACK);
  assign step_fwd = new_pat && is_ph && (dec[1:0] == q + 2'd1);
  assign step_bwd = new_pat && is_ph && (dec[1:0] == q - 2'd1);
  assign step_opp = new_pat && is_ph && (dec[1:0] == q + 2'd2);
  assign pos_ext  = 32'(pos_nxt);

  always_comb begin
    pos_nxt = position;
    if (step_fwd)      pos_nxt = sat_inc(position);
    else if (step_bwd) pos_nxt = sat_dec(position);
    if (zero_pos)      pos_nxt = '0;
  end

  // Stage 3: tracking FSM and registered outputs
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state        <= NOREF;
      q            <= 2'd0;
      position     <= '0;
      step_pulse   <= 1'b0;
      step_dir     <= 1'b0;
      energized    <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= 2'b00;
      at_fwd_limit <= 1'b0;
      at_bwd_limit <= 1'b0;
    end else begin
      step_pulse   <= step_fwd | step_bwd;
      energized    <= is_ph;
      position     <= pos_nxt;
      at_fwd_limit <= (pos_ext >= LIMIT_FWD);
      at_bwd_limit <= (pos_ext <= LIMIT_BWD);
      if (step_fwd)      step_dir <= 1'b1;
      else if (step_bwd) step_dir <= 1'b0;
      case (state)
        NOREF: begin
          // An illegal accepted pattern faults even without a fresh acceptance
          if (is_ill) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= 2'b01;
          end else if (vld_p2 && is_ph) begin
            state <= TRACK;
            q     <= dec[1:0];
          end
        end
        TRACK: begin
          if (vld_p2) begin
            if (is_ill) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b01;
            end else if (step_opp) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b10;
            end else if (step_fwd || step_bwd) begin
              q <= dec[1:0];
            end
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state      <= NOREF;
            fault      <= 1'b0;
            fault_code <= 2'b00;
          end
        end
        default: state <= NOREF;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_phase_monitor.sv
// Bench for stepper_phase_monitor: default-parameter instance for tracking/faults,
// narrow-position instance for saturation, soft limits and zero_pos coincidence.
module tb_stepper_phase_monitor;

  localparam int SC_A = 16;
  localparam int SC_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, rst_b;
  logic [3:0]        coil_a, coil_b;
  logic              zp_a, zp_b, clr_a, clr_b;
  logic signed [15:0] pos_a;
  logic signed [3:0]  pos_b;
  logic              sp_a, sd_a, en_a, f_a, fl_a, bl_a;
  logic              sp_b, sd_b, en_b, f_b, fl_b, bl_b;
  logic [1:0]        fc_a, fc_b;

  stepper_phase_monitor #(.STABLE_CYCLES(SC_A)) dut_a (
    .CLK100MHZ(clk), .CPU_RESETN(rst_a), .coil(coil_a), .zero_pos(zp_a),
    .clear_fault(clr_a), .position(pos_a), .step_pulse(sp_a), .step_dir(sd_a),
    .energized(en_a), .fault(f_a), .fault_code(fc_a),
    .at_fwd_limit(fl_a), .at_bwd_limit(bl_a));

  stepper_phase_monitor #(.STABLE_CYCLES(SC_B), .POS_WIDTH(4), .LIMIT_FWD(5), .LIMIT_BWD(-5)) dut_b (
    .CLK100MHZ(clk), .CPU_RESETN(rst_b), .coil(coil_b), .zero_pos(zp_b),
    .clear_fault(clr_b), .position(pos_b), .step_pulse(sp_b), .step_dir(sd_b),
    .energized(en_b), .fault(f_b), .fault_code(fc_b),
    .at_fwd_limit(fl_b), .at_bwd_limit(bl_b));

  int pc_a = 0;
  int pc_b = 0;
  always @(posedge clk) #1 if (sp_a) pc_a = pc_a + 1;
  always @(posedge clk) #1 if (sp_b) pc_b = pc_b + 1;

  typedef struct {
    logic [3:0] coil;
    int zp, clr, hold;
    int pos, pulses, dir, en, flt, code, fl, bl;
  } vec_t;

  vec_t vecs[22];
  vec_t sbq[$];
  int n_app = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic [3:0] c, input int zp, input int clr, input int pos,
                              input int pul, input int dir, input int en, input int flt,
                              input int code, input int hold);
    vec_t v;
    v.coil = c; v.zp = zp; v.clr = clr; v.hold = hold;
    v.pos = pos; v.pulses = pul; v.dir = dir; v.en = en; v.flt = flt; v.code = code;
    v.fl = 0; v.bl = 0;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_app++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int sel, input vec_t v, input string tag);
    vec_t e;
    int p0;
    @(negedge clk);
    if (sel == 0) begin
      coil_a = v.coil; zp_a = (v.zp != 0); clr_a = (v.clr != 0); p0 = pc_a;
    end else begin
      coil_b = v.coil; zp_b = (v.zp != 0); clr_b = (v.clr != 0); p0 = pc_b;
    end
    sbq.push_back(v);
    @(negedge clk);
    zp_a = 1'b0; clr_a = 1'b0; zp_b = 1'b0; clr_b = 1'b0;
    repeat (v.hold - 1) @(negedge clk);
    if (sbq.size() == 0) begin
      chk({tag, ".queue"}, 0, 1);
      return;
    end
    e = sbq.pop_front();
    if (sel == 0) begin
      chk({tag, ".pos"}, pos_a, e.pos);
      chk({tag, ".pulses"}, pc_a - p0, e.pulses);
      chk({tag, ".dir"}, sd_a, e.dir);
      chk({tag, ".energized"}, en_a, e.en);
      chk({tag, ".fault"}, f_a, e.flt);
      chk({tag, ".code"}, fc_a, e.code);
      chk({tag, ".fwd_lim"}, fl_a, e.fl);
      chk({tag, ".bwd_lim"}, bl_a, e.bl);
    end else begin
      chk({tag, ".pos"}, pos_b, e.pos);
      chk({tag, ".pulses"}, pc_b - p0, e.pulses);
      chk({tag, ".dir"}, sd_b, e.dir);
      chk({tag, ".energized"}, en_b, e.en);
      chk({tag, ".fault"}, f_b, e.flt);
      chk({tag, ".fwd_lim"}, fl_b, e.fl);
      chk({tag, ".bwd_lim"}, bl_b, e.bl);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat [4];
    vec_t v;
    int p0, lat, found, exp_pos;
    pat[0] = 4'b1001; pat[1] = 4'b1010; pat[2] = 4'b0110; pat[3] = 4'b0101;

    //         coil      zp clr pos pul dir en flt code hold
    vecs[0]  = mk(4'b1001, 0, 0, 0, 0, 0, 1, 0, 0, 20);
    vecs[1]  = mk(4'b1010, 0, 0, 1, 1, 1, 1, 0, 0, 20);
    vecs[2]  = mk(4'b0110, 0, 0, 2, 1, 1, 1, 0, 0, 20);
    vecs[3]  = mk(4'b0101, 0, 0, 3, 1, 1, 1, 0, 0, 20);
    vecs[4]  = mk(4'b1001, 0, 0, 4, 1, 1, 1, 0, 0, 20);
    vecs[5]  = mk(4'b0101, 0, 0, 3, 1, 0, 1, 0, 0, 20);
    vecs[6]  = mk(4'b0110, 0, 0, 2, 1, 0, 1, 0, 0, 20);
    vecs[7]  = mk(4'b0000, 0, 0, 2, 0, 0, 0, 0, 0, 20);
    vecs[8]  = mk(4'b0101, 0, 0, 3, 1, 1, 1, 0, 0, 20);
    vecs[9]  = mk(4'b1001, 0, 0, 4, 1, 1, 1, 0, 0, 20);
    vecs[10] = mk(4'b0110, 0, 0, 4, 0, 1, 1, 1, 2, 20);
    vecs[11] = mk(4'b1010, 0, 0, 4, 0, 1, 1, 1, 2, 20);
    vecs[12] = mk(4'b1010, 0, 1, 4, 0, 1, 1, 0, 0, 20);
    vecs[13] = mk(4'b0110, 0, 0, 4, 0, 1, 1, 0, 0, 20);
    vecs[14] = mk(4'b0101, 0, 0, 5, 1, 1, 1, 0, 0, 20);
    vecs[15] = mk(4'b1111, 0, 0, 5, 0, 1, 0, 1, 1, 20);
    vecs[16] = mk(4'b1111, 0, 1, 5, 0, 1, 0, 1, 1, 20);
    vecs[17] = mk(4'b1001, 0, 0, 5, 0, 1, 1, 1, 1, 20);
    vecs[18] = mk(4'b1001, 0, 1, 5, 0, 1, 1, 0, 0, 20);
    vecs[19] = mk(4'b1010, 0, 0, 5, 0, 1, 1, 0, 0, 20);
    vecs[20] = mk(4'b0110, 0, 0, 6, 1, 1, 1, 0, 0, 20);
    vecs[21] = mk(4'b0110, 1, 0, 0, 0, 1, 1, 0, 0, 20);

    rst_a = 1'b0; rst_b = 1'b0;
    coil_a = 4'b0; coil_b = 4'b0;
    zp_a = 1'b0; zp_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.pos", pos_a, 0);
    chk("rst.pulse", sp_a, 0);
    chk("rst.dir", sd_a, 0);
    chk("rst.energized", en_a, 0);
    chk("rst.fault", f_a, 0);
    chk("rst.code", fc_a, 0);
    chk("rst.fwd_lim", fl_a, 0);
    chk("rst.bwd_lim", bl_a, 0);
    rst_a = 1'b1; rst_b = 1'b1;

    for (int i = 0; i < 22; i++) run_vec(0, vecs[i], $sformatf("vec%0d", i));

    // Input-pin to step_pulse latency, and single-cycle pulse width
    @(negedge clk);
    coil_a = 4'b0101;
    found = 0; lat = -1;
    for (int k = 1; k <= 40 && found == 0; k++) begin
      @(posedge clk); #1;
      if (sp_a) begin found = 1; lat = k; end
    end
    chk("latency", lat, SC_A + 3);
    chk("lat.pos", pos_a, 1);
    chk("lat.dir", sd_a, 1);
    @(posedge clk); #1;
    chk("pulse_width", sp_a, 0);

    // Short glitch must be filtered
    @(negedge clk);
    p0 = pc_a;
    coil_a = 4'b1010;
    repeat (3) @(negedge clk);
    coil_a = 4'b0101;
    repeat (30) @(negedge clk);
    chk("glitch.pulses", pc_a - p0, 0);
    chk("glitch.pos", pos_a, 1);
    chk("glitch.fault", f_a, 0);

    // Reset mid-operation discards position and reference
    rst_a = 1'b0;
    #2;
    chk("midrst.pos", pos_a, 0);
    chk("midrst.energized", en_a, 0);
    chk("midrst.dir", sd_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    run_vec(0, mk(4'b0101, 0, 0, 0, 0, 0, 1, 0, 0, 25), "reref");
    run_vec(0, mk(4'b0110, 0, 0, -1, 1, 0, 1, 0, 0, 20), "reref_ccw");

    // Narrow instance: saturation and forward limit
    run_vec(1, mk(4'b1001, 0, 0, 0, 0, 0, 1, 0, 0, 10), "b_ref");
    for (int i = 1; i <= 8; i++) begin
      exp_pos = (i > 7) ? 7 : i;
      v = mk(pat[i % 4], 0, 0, exp_pos, 1, 1, 1, 0, 0, 10);
      v.fl = (exp_pos >= 5) ? 1 : 0;
      run_vec(1, v, $sformatf("b_cw%0d", i));
    end

    // zero_pos landing on the same edge as a counted step
    @(negedge clk);
    coil_b = 4'b1010;
    repeat (SC_B + 2) @(posedge clk);
    @(negedge clk);
    zp_b = 1'b1;
    @(posedge clk); #1;
    chk("zstep.pos", pos_b, 0);
    chk("zstep.pulse", sp_b, 1);
    chk("zstep.dir", sd_b, 1);
    chk("zstep.fwd_lim", fl_b, 0);
    @(negedge clk);
    zp_b = 1'b0;
    repeat (4) @(negedge clk);

    // Backward steps to the backward limit
    for (int i = 1; i <= 6; i++) begin
      v = mk(pat[(1 - i) & 3], 0, 0, -i, 1, 0, 1, 0, 0, 10);
      v.bl = (-i <= -5) ? 1 : 0;
      run_vec(1, v, $sformatf("b_ccw%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
    $finish;
  end

endmodule
